// File: rtl/fifo_bit_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_deser_pkg
// Brief    : Shared state encoding and sizing helper for the bit deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_deser_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } deser_state_t;

  function automatic int beats(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_bit_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bit_deserializer_if
// Brief    : FIFO-side and output-side handshake bundle of the deserializer.
//            out_parity_o exists only when FIFO_DESER_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_bit_deserializer_if #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 4
);

  logic             fifo_empty_i;
  logic [IN_W-1:0]  fifo_data_i;
  logic             fifo_pop_o;
  logic             out_valid_o;
  logic [OUT_W-1:0] out_data_o;
  logic             out_ready_i;
`ifdef FIFO_DESER_PARITY_EN
  logic             out_parity_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_pop_o, out_valid_o, out_data_o, out_parity_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_pop_o, out_valid_o, out_data_o, out_parity_o
  );
`else
  modport master (
    input  fifo_empty_i, fifo_data_i, out_ready_i,
    output fifo_pop_o, out_valid_o, out_data_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, out_ready_i,
    input  fifo_pop_o, out_valid_o, out_data_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/fifo_bit_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bit_deserializer
// Brief    : Pops IN_W-bit beats from a FWFT FIFO and packs OUT_W/IN_W of them
//            LSB-first into a word on a valid/ready port. Optional even-parity
//            output under macro FIFO_DESER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_bit_deserializer
  import fifo_deser_pkg::*;
#(
  parameter int IN_W  = 1,
  parameter int OUT_W = 4
) (
  input  wire                      clk,
  input  wire                      reset,
  fifo_bit_deserializer_if.master  bus
);

  localparam int BEATS = beats(IN_W, OUT_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((OUT_W % IN_W) != 0 || (OUT_W / IN_W) < 2) begin : g_bad_params
      $error("fifo_bit_deserializer: OUT_W must be a multiple of IN_W with at least 2 beats");
    end
  endgenerate

  deser_state_t     r_state;
  deser_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0] r_shift;
  logic [OUT_W-1:0] w_shift_nxt;
  logic             r_out_valid;
  logic             w_valid_nxt;
  logic [OUT_W-1:0] r_out_data;
  logic [OUT_W-1:0] w_data_nxt;
  logic [OUT_W-1:0] w_word;
  logic             w_pop;
  logic             w_last_beat;
  logic             w_out_free;
  logic             w_load;

  // Pop is held low while reset is asserted, independent of FIFO state.
  assign w_pop       = reset && (r_state == FILL) && !bus.fifo_empty_i;
  assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);
  assign w_out_free  = !r_out_valid || bus.out_ready_i;

  always_comb begin
    w_word = r_shift;
    w_word[r_beat_cnt*IN_W +: IN_W] = bus.fifo_data_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_shift_nxt = r_shift;
    w_valid_nxt = r_out_valid;
    w_data_nxt  = r_out_data;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        if (r_out_valid && bus.out_ready_i) begin
          w_valid_nxt = 1'b0;
        end
        if (w_pop) begin
          if (!w_last_beat) begin
            w_shift_nxt = w_word;
            w_cnt_nxt   = r_beat_cnt + 1'b1;
          end else if (w_out_free) begin
            w_data_nxt  = w_word;
            w_valid_nxt = 1'b1;
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
          end else begin
            // Output still occupied: park the completed word until it drains.
            w_shift_nxt = w_word;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.out_ready_i) begin
          w_data_nxt  = r_shift;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FILL;
      r_beat_cnt  <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
    end
  end

  assign bus.fifo_pop_o  = w_pop;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;

`ifdef FIFO_DESER_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^w_data_nxt;
    end
  end

  assign bus.out_parity_o = r_parity;
`else
  logic w_load_unused;
  assign w_load_unused = w_load;
`endif

endmodule
`default_nettype wire
